// File: rtl/move_shift_unit.sv
// Iterative MOV/MVN/LSL/LSR/ASR/ROR/RRX unit: up to STEP bit positions per cycle, done pulse in cycle k+1.
// start is taken only while ready is high; requests made while busy are dropped, not queued.
module move_shift_unit #(
    parameter int N    = 32,
    parameter int STEP = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [2:0]   op,
    input  logic [N-1:0] a,
    input  logic [7:0]   amt,
    input  logic         c_in,
    input  logic         v_in,
    output logic         ready,
    output logic         done,
    output logic [N-1:0] result,
    output logic [3:0]   flags
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [2:0] OP_MOV = 3'b000;
    localparam logic [2:0] OP_MVN = 3'b001;
    localparam logic [2:0] OP_LSL = 3'b010;
    localparam logic [2:0] OP_LSR = 3'b011;
    localparam logic [2:0] OP_ASR = 3'b100;
    localparam logic [2:0] OP_ROR = 3'b101;
    localparam logic [2:0] OP_RRX = 3'b110;

    localparam logic [31:0] SAT   = 32'(N + 1);
    localparam logic [7:0]  STEP8 = 8'(STEP);

    logic [1:0]   state;
    logic [2:0]   op_q;
    logic [N-1:0] work;
    logic         carry;
    logic         v_q;
    logic [7:0]   rem;

    logic [31:0]  amt_w;
    logic [7:0]   rem_init;
    logic [N-1:0] work_init;
    logic         carry_init;
    logic [2:0]   op_init;

    logic [7:0]   s;
    logic [7:0]   rem_nxt;
    logic [N-1:0] w_nxt;
    logic         c_nxt;

    always_comb begin
        amt_w      = {24'd0, amt};
        rem_init   = 8'd0;
        work_init  = a;
        carry_init = c_in;
        op_init    = op;
        case (op)
            OP_LSL, OP_LSR, OP_ASR: rem_init = (amt_w > SAT) ? 8'(SAT) : amt;
            OP_ROR:                 rem_init = 8'(amt_w % 32'(N));
            OP_MVN:                 work_init = ~a;
            OP_RRX: begin
                work_init  = {c_in, a[N-1:1]};
                carry_init = a[0];
            end
            OP_MOV:                 ;
            default:                op_init = OP_MOV;
        endcase
        // Full-turn rotation leaves a unchanged but still reports the top bit as carry.
        if (op == OP_ROR && amt != 8'd0 && rem_init == 8'd0)
            carry_init = a[N-1];
    end

    always_comb begin
        s     = (rem > STEP8) ? STEP8 : rem;
        w_nxt = work;
        c_nxt = carry;
        for (int i = 0; i < STEP; i++) begin
            if (i < int'(s)) begin
                case (op_q)
                    OP_LSL: begin c_nxt = w_nxt[N-1]; w_nxt = {w_nxt[N-2:0], 1'b0}; end
                    OP_LSR: begin c_nxt = w_nxt[0];   w_nxt = {1'b0, w_nxt[N-1:1]}; end
                    OP_ASR: begin c_nxt = w_nxt[0];   w_nxt = {w_nxt[N-1], w_nxt[N-1:1]}; end
                    OP_ROR: begin c_nxt = w_nxt[0];   w_nxt = {w_nxt[0], w_nxt[N-1:1]}; end
                    default: ;
                endcase
            end
        end
        rem_nxt = rem - s;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            op_q   <= OP_MOV;
            work   <= '0;
            carry  <= 1'b0;
            v_q    <= 1'b0;
            rem    <= 8'd0;
            result <= '0;
            flags  <= 4'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q  <= op_init;
                        work  <= work_init;
                        carry <= carry_init;
                        v_q   <= v_in;
                        rem   <= rem_init;
                        state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    work  <= w_nxt;
                    carry <= c_nxt;
                    rem   <= rem_nxt;
                    if (rem_nxt == 8'd0) begin
                        result <= w_nxt;
                        flags  <= {w_nxt[N-1], (w_nxt == '0), c_nxt, v_q};
                        state  <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign ready = (state == S_IDLE) && !rst;
    assign done  = (state == S_DONE) && !rst;

endmodule

// File: doc/move_shift_unit.md
# move_shift_unit

Multi-cycle move/shift execution unit for the ALU datapath, generalising the plain register move to MOV, MVN, LSL, LSR, ASR, ROR and RRX with a register-specified shift amount. It produces NZCV flags and uses a start/ready/done handshake so the control unit can stall while it runs. Shifting is iterative, at STEP bit positions per cycle, which trades latency for area.

## Interface
- N, 32, operand and result width (≥ 4)
- STEP, 1, maximum bit positions shifted per cycle (1, 2, 4 or 8; STEP ≤ N)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request; accepted only when ready=1
- op  in  3  000 MOV, 001 MVN, 010 LSL, 011 LSR, 100 ASR, 101 ROR, 110 RRX, 111 treated as MOV
- a  in  N  source operand
- amt  in  8  shift amount, unsigned 0..255; ignored for MOV, MVN and RRX
- c_in  in  1  current carry flag
- v_in  in  1  current overflow flag
- ready  out  1  high in IDLE; start is accepted on an edge where start & ready
- done  out  1  one-cycle pulse; result and flags valid from this cycle
- result  out  N  registered result
- flags  out  4  registered {N, Z, C, V}

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE to SHIFT on accept. Latch op, a, c_in, v_in and the remaining count rem:
  - LSL, LSR, ASR: rem = min(amt, N+1).
  - ROR: rem = amt mod N.
  - MOV, MVN, RRX: rem = 0.
- SHIFT, each cycle: shift the working register by s = min(STEP, rem), set rem -= s, and update carry to the last bit shifted out when s > 0. Move to DONE when rem reaches 0 after the update, or when rem was already 0 on entry.
- Shift fill rules:
  - LSL fills with 0.
  - LSR fills with 0.
  - ASR fills with a[N-1].
  - ROR fills with the bits rotated out.
  - RRX: result = {c_in, a[N-1:1]}, C = a[0].
- Saturation gives the architectural semantics with no special cases:
  - LSL/LSR, amt = N: result 0, C = the last bit out.
  - LSL/LSR, amt > N: result 0, C = 0.
  - ASR, amt ≥ N: result is all sign bits, C = sign.
- ROR special case: amt ≠ 0 and amt mod N = 0 gives result = a and C = a[N-1].
- Shift ops with amt = 0: result = a, C = c_in.
- MOV: result = a, C = c_in.
- MVN: result = ~a, C = c_in.
- Flags: N = result[N-1]; Z = (result == 0); V = latched v_in.
- DONE: result and flags are loaded on the edge entering DONE, done = 1 for that one cycle, then return to IDLE. result and flags hold until the next DONE or reset.
- start while ready = 0 is ignored and not queued. Inputs are sampled only at accept.

## Timing
- Accept edge is cycle 0. SHIFT occupies cycles 1..k, where k = max(1, ceil(rem/STEP)). done is high in cycle k+1. ready is high again in cycle k+2.
- Minimum latency (MOV, MVN, RRX, or amt = 0) is done in cycle 2. Maximum latency is k = ceil((N+1)/STEP).
- Back-to-back: start may be held high; the next op is accepted on the first edge where ready = 1.
- Reset:
  - While rst is high: state IDLE, ready = 0, done = 0, result = 0, flags = 0.
  - ready = 1 from the first cycle after rst deasserts.
  - rst mid-operation aborts with no done pulse. result and flags are cleared to 0, not the partial value.

## Test plan
- Reset/idle: assert rst for 2 cycles during a SHIFT. Require done = 0, result = 0, flags = 0, and ready = 1 in the cycle after release.
- MOV/MVN: N = 32, a = 0x0000_0000, op MOV → result 0, flags Z = 1, done in cycle 2. Then op MVN → result 0xFFFF_FFFF, N = 1, Z = 0, C = c_in.
- LSL/LSR boundaries, STEP = 1, a = 0x8000_0001:
  - LSL amt 1 → 0x0000_0002, C = 1.
  - LSL amt 32 → 0, C = 1, Z = 1, done in cycle 33.
  - LSR amt 33 → 0, C = 0.
  - LSR amt 200 → same result and latency as amt 33.
- ASR/ROR, STEP = 4:
  - a = 0x8000_0010, ASR amt 5 → 0xFC00_0000, C = 1, k = 2.
  - ASR amt 40 → 0xFFFF_FFFF, C = 1.
  - ROR amt 4 → 0x0800_0001, C = 0.
  - ROR amt 64 → a unchanged, C = 1.
- RRX and amt = 0: c_in = 1, a = 0x0000_0003, RRX → 0x8000_0001, C = 1. LSL amt 0 with c_in = 0 → result a, C = 0, done in cycle 2.
- Handshake: pulse start during SHIFT with different operands → ignored, first result unchanged. Hold start high across two ops → second accepted exactly in cycle k+2. v_in = 1 propagates to flags V.
